// File: rtl/leaf_delta_decode.sv
// Snapshot-differencing decoder for the leaf_delta accumulator readback stream.
// Define LEAF_DELTA_DECODE_SKID_EN to add a 2-entry skid buffer with a registered in_ready.
module leaf_delta_decode #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_delta,
  output logic [1:0]       out_a_hi,
  output logic [1:0]       out_b_lo,
  output logic             out_first,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx
);

  localparam int BEAT_W = WIDTH + 2 + CNT_W;

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   prev;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idx_next;
  logic [CNT_W-1:0]   beat_idx;
  logic               beat_first;
  logic               accept;
  logic [WIDTH-1:0]   beat_delta;
  logic [BEAT_W-1:0]  beat;
  logic [BEAT_W-1:0]  head;

  assign accept     = in_valid && in_ready;
  assign beat_delta = in_acc - prev;
  assign beat       = {beat_delta, beat_first, in_last, beat_idx};

  always_comb begin
    state_next = state;
    beat_first = 1'b0;
    beat_idx   = idx;
    case (state)
      FIRST: begin
        beat_first = 1'b1;
        beat_idx   = '0;
        if (accept && !in_last) state_next = MID;
      end
      MID: begin
        if (accept && in_last) state_next = FIRST;
      end
      default: state_next = FIRST;
    endcase
  end

  // idx always holds the tag the next beat would get; it saturates instead of wrapping.
  always_comb begin
    idx_next = idx;
    if (accept) begin
      if (in_last) begin
        idx_next = '0;
      end else if (beat_idx == {CNT_W{1'b1}}) begin
        idx_next = beat_idx;
      end else begin
        idx_next = beat_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
      idx   <= '0;
      prev  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (accept) begin
        prev <= in_last ? '0 : in_acc;
      end
    end
  end

`ifdef LEAF_DELTA_DECODE_SKID_EN
  logic [BEAT_W-1:0] ent0;
  logic [BEAT_W-1:0] ent1;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              ready_q;
  logic              pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_q;
  assign head      = ent0;

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // ent0 is the head seen by the sink; ent1 only fills while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0    <= '0;
      ent1    <= '0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next < 2'd2);
      if (pop) begin
        if (accept) begin
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= beat;
          end else begin
            ent0 <= beat;
          end
        end else begin
          ent0 <= ent1;
        end
      end else if (accept) begin
        if (count == 2'd0) begin
          ent0 <= beat;
        end else begin
          ent1 <= beat;
        end
      end
    end
  end
`else
  logic [BEAT_W-1:0] out_q;
  logic              valid_q;
  logic              ready_en;

  // ready_en keeps in_ready low through the cycle in which reset releases.
  assign in_ready  = ready_en && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign head      = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      valid_q  <= accept || (valid_q && !out_ready);
      if (accept) begin
        out_q <= beat;
      end
    end
  end
`endif

  assign {out_delta, out_first, out_last, out_idx} = head;
  assign out_a_hi = out_delta[WIDTH-1:WIDTH-2];
  assign out_b_lo = out_delta[1:0];

endmodule

// File: tb/tb_leaf_delta_decode.sv
// Self-checking bench for leaf_delta_decode: queue-based frame model plus directed
// literal checks, and a CNT_W=2 instance for index saturation.
module tb_leaf_delta_decode;

  typedef struct packed {
    logic [15:0] delta;
    logic        first;
    logic        last;
    logic [7:0]  idx;
    logic [1:0]  a_hi;
    logic [1:0]  b_lo;
  } beat_t;

`ifdef LEAF_DELTA_DECODE_SKID_EN
  localparam int BP_ACCEPT = 2;
`else
  localparam int BP_ACCEPT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_acc;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_delta;
  logic [1:0]  out_a_hi;
  logic [1:0]  out_b_lo;
  logic        out_first;
  logic        out_last;
  logic [7:0]  out_idx;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_in_acc;
  logic        s_in_last;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_delta;
  logic [1:0]  s_out_a_hi;
  logic [1:0]  s_out_b_lo;
  logic        s_out_first;
  logic        s_out_last;
  logic [1:0]  s_out_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [1:0]  s_idx_q[$];

  logic [15:0] m_prev = '0;
  int          m_pos  = 0;
  logic        l_acc_fire = 1'b0;
  logic        l_pop_fire = 1'b0;
  logic [15:0] l_acc = '0;
  logic        l_last = 1'b0;
  beat_t       l_got;
  beat_t       e;
  logic        prev_rst = 1'b0;
  logic        armed;
  logic        exp_ready;

  always #5 clk = ~clk;

  leaf_delta_decode #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_delta(out_delta),
    .out_a_hi(out_a_hi), .out_b_lo(out_b_lo), .out_first(out_first),
    .out_last(out_last), .out_idx(out_idx)
  );

  leaf_delta_decode #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_acc(s_in_acc), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_delta(s_out_delta),
    .out_a_hi(s_out_a_hi), .out_b_lo(s_out_b_lo), .out_first(s_out_first),
    .out_last(s_out_last), .out_idx(s_out_idx)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: events seen at the previous negedge took effect on the posedge in between.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_prev     = '0;
        m_pos      = 0;
        l_acc_fire = 1'b0;
        l_pop_fire = 1'b0;
      end else begin
        if (l_pop_fire) begin
          if (exp_q.size() > 0) exp_q.delete(0);
          got_q.push_back(l_got);
        end
        if (l_acc_fire) begin
          e.delta = l_acc - m_prev;
          e.first = (m_pos == 0);
          e.last  = l_last;
          e.idx   = (m_pos > 255) ? 8'd255 : m_pos[7:0];
          e.a_hi  = e.delta[15:14];
          e.b_lo  = e.delta[1:0];
          exp_q.push_back(e);
          n_accept++;
          if (l_last) begin
            m_prev = '0;
            m_pos  = 0;
          end else begin
            m_prev = l_acc;
            m_pos++;
          end
        end
      end
      armed    = prev_rst && rst_n;
      prev_rst = rst_n;
`ifdef LEAF_DELTA_DECODE_SKID_EN
      exp_ready = armed && (exp_q.size() < 2);
`else
      exp_ready = armed && (exp_q.size() == 0 || out_ready);
`endif
      check_output("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check_output("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (out_valid && exp_q.size() != 0) begin
        check_output("out_delta", {16'd0, out_delta}, {16'd0, exp_q[0].delta});
        check_output("out_first", {31'd0, out_first}, {31'd0, exp_q[0].first});
        check_output("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
        check_output("out_idx", {24'd0, out_idx}, {24'd0, exp_q[0].idx});
        check_output("out_a_hi", {30'd0, out_a_hi}, {30'd0, exp_q[0].a_hi});
        check_output("out_b_lo", {30'd0, out_b_lo}, {30'd0, exp_q[0].b_lo});
      end
      l_acc_fire = rst_n && in_valid && in_ready;
      l_pop_fire = rst_n && out_valid && out_ready;
      l_acc      = in_acc;
      l_last     = in_last;
      l_got      = '{delta: out_delta, first: out_first, last: out_last, idx: out_idx,
                     a_hi: out_a_hi, b_lo: out_b_lo};
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && s_out_valid && s_out_ready) s_idx_q.push_back(s_out_idx);
    end
  end

  // Drives one beat and holds it until it is accepted; call at posedge+1.
  task automatic apply_stimulus(input logic [15:0] acc, input logic last);
    logic took;
    took     = 1'b0;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    for (int k = 0; k < 50 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) check_output("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 200 && got_q.size() < n; k++) @(posedge clk);
    #1;
    check_output("delivered_count", got_q.size(), n);
  endtask

  logic [15:0] t1_d[3];
  int          a0;
  int          g0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_acc = '0; in_last = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_acc = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("reset_out_delta", {16'd0, out_delta}, 32'd0);
    check_output("reset_out_idx", {24'd0, out_idx}, 32'd0);
    check_output("reset_first_last", {30'd0, out_first, out_last}, 32'd0);
    rst_n = 1'b1;
    check_output("ready_release_cycle", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_output("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Basic frame
    $display("[TB] basic frame");
    got_q.delete();
    apply_stimulus(16'h0010, 1'b0);
    apply_stimulus(16'h0030, 1'b0);
    apply_stimulus(16'h0030, 1'b1);
    wait_got(3);
    t1_d = '{16'h0010, 16'h0020, 16'h0000};
    if (got_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check_output("basic_delta", {16'd0, got_q[i].delta}, {16'd0, t1_d[i]});
        check_output("basic_idx", {24'd0, got_q[i].idx}, i);
        check_output("basic_first", {31'd0, got_q[i].first}, {31'd0, i == 0});
        check_output("basic_last", {31'd0, got_q[i].last}, {31'd0, i == 2});
      end
    end

    // Partial recovery on a single-beat frame
    $display("[TB] partial recovery");
    got_q.delete();
    apply_stimulus(16'hC003, 1'b1);
    wait_got(1);
    if (got_q.size() >= 1) begin
      check_output("partial_delta", {16'd0, got_q[0].delta}, 32'h0000C003);
      check_output("partial_a_hi", {30'd0, got_q[0].a_hi}, 32'd3);
      check_output("partial_b_lo", {30'd0, got_q[0].b_lo}, 32'd3);
      check_output("partial_first_last", {30'd0, got_q[0].first, got_q[0].last}, 32'd3);
    end

    // Wrap-around and immediate next frame
    $display("[TB] wrap");
    got_q.delete();
    apply_stimulus(16'hFFF0, 1'b0);
    apply_stimulus(16'h0010, 1'b1);
    apply_stimulus(16'h0005, 1'b1);
    wait_got(3);
    if (got_q.size() >= 3) begin
      check_output("wrap_delta0", {16'd0, got_q[0].delta}, 32'h0000FFF0);
      check_output("wrap_delta1", {16'd0, got_q[1].delta}, 32'h00000020);
      check_output("wrap_delta2", {16'd0, got_q[2].delta}, 32'h00000005);
      check_output("wrap_next_first", {31'd0, got_q[2].first}, 32'd1);
    end

    // Backpressure from idle
    $display("[TB] backpressure");
    got_q.delete();
    out_ready = 1'b0;
    a0 = n_accept;
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_acc = 16'h0100 + 16'(i * 16'h0011);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("bp_accepted", n_accept - a0, BP_ACCEPT);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_got(BP_ACCEPT);
    apply_stimulus(16'h0400, 1'b1);
    wait_got(BP_ACCEPT + 1);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    apply_stimulus(16'h0001, 1'b0);
    apply_stimulus(16'h0002, 1'b0);
    apply_stimulus(16'h0003, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    apply_stimulus(16'h0040, 1'b1);
    wait_got(1);
    if (got_q.size() >= 1) begin
      check_output("midreset_delta", {16'd0, got_q[0].delta}, 32'h00000040);
      check_output("midreset_first", {31'd0, got_q[0].first}, 32'd1);
      check_output("midreset_idx", {24'd0, got_q[0].idx}, 32'd0);
    end

    // Index saturation on the CNT_W=2 instance
    $display("[TB] saturation");
    s_idx_q.delete();
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1'b1;
      s_in_acc   = 16'(i * 3);
      s_in_last  = (i == 5);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("sat_count", s_idx_q.size(), 6);
    if (s_idx_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check_output("sat_idx", {30'd0, s_idx_q[i]}, (i > 3) ? 3 : i);
      end
    end

    // Randomized traffic with random backpressure
    $display("[TB] random traffic");
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_acc    = 16'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(negedge clk);
    check_output("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
